phase_sequencer: RTL and testbench

// - Traffic-light phase timer: steps car/pedestrian phases at 1 s resolution and emits the

---
 rtl/tl_pkg.sv | 33 +++
 rtl/tick_prescaler.sv | 24 ++
 rtl/phase_sequencer.sv | 90 +++++++++
 tb/tb_phase_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: phase codes (also used by the display controller)
// and default phase durations in seconds.
package tl_pkg;

  typedef enum logic [2:0] {
    PH_CAR_GREEN  = 3'd0,
    PH_CAR_YELLOW = 3'd1,
    PH_ALL_RED_A  = 3'd2,
    PH_WALK       = 3'd3,
    PH_WALK_FLASH = 3'd4,
    PH_ALL_RED_B  = 3'd5
  } phase_e;

  localparam int DEF_T_CAR_GREEN  = 9;
  localparam int DEF_T_CAR_YELLOW = 3;
  localparam int DEF_T_ALL_RED    = 2;
  localparam int DEF_T_WALK       = 9;
  localparam int DEF_T_WALK_FLASH = 5;
  localparam int DEF_T_PED_CUT    = 3;

  // Fixed phase ring; the CAR_GREEN rest/exit decision is made by the caller.
  function automatic logic [2:0] next_phase(input logic [2:0] ph);
    case (ph)
      PH_CAR_GREEN:  next_phase = PH_CAR_YELLOW;
      PH_CAR_YELLOW: next_phase = PH_ALL_RED_A;
      PH_ALL_RED_A:  next_phase = PH_WALK;
      PH_WALK:       next_phase = PH_WALK_FLASH;
      PH_WALK_FLASH: next_phase = PH_ALL_RED_B;
      default:       next_phase = PH_CAR_GREEN;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a 1 s strobe; the count holds while en is low so a pause
// resumes exactly where it left off.
module tick_prescaler #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/phase_sequencer.sv
// Traffic-light phase timer: walks the car/pedestrian phase ring at 1 s resolution,
// latches pedestrian requests and shortens car green when someone is waiting.
module phase_sequencer
  import tl_pkg::*;
#(
  parameter int TICK_DIV     = 25_000_000,
  parameter int T_CAR_GREEN  = DEF_T_CAR_GREEN,
  parameter int T_CAR_YELLOW = DEF_T_CAR_YELLOW,
  parameter int T_ALL_RED    = DEF_T_ALL_RED,
  parameter int T_WALK       = DEF_T_WALK,
  parameter int T_WALK_FLASH = DEF_T_WALK_FLASH,
  parameter int T_PED_CUT    = DEF_T_PED_CUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ped_req,
  output logic [2:0] phase,
  output logic [3:0] count,
  output logic       tick,
  output logic       ped_pending
);

  logic       fire;
  logic       ped_any;
  logic       cut;
  logic [2:0] phase_n;
  logic [3:0] count_n;
  logic       pend_n;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (fire)
  );

  function automatic logic [3:0] phase_dur(input logic [2:0] ph);
    case (ph)
      PH_CAR_GREEN:  phase_dur = 4'(T_CAR_GREEN);
      PH_CAR_YELLOW: phase_dur = 4'(T_CAR_YELLOW);
      PH_WALK:       phase_dur = 4'(T_WALK);
      PH_WALK_FLASH: phase_dur = 4'(T_WALK_FLASH);
      default:       phase_dur = 4'(T_ALL_RED);
    endcase
  endfunction

  // A same-cycle request counts as already latched for both the cut and the green exit.
  assign ped_any = ped_req || ped_pending;
  assign cut     = (phase == PH_CAR_GREEN) && ped_any && (count > 4'(T_PED_CUT));

  always_comb begin
    phase_n = phase;
    count_n = count;
    pend_n  = ped_pending;
    if (phase > PH_ALL_RED_B) begin
      phase_n = PH_ALL_RED_A;
      count_n = 4'(T_ALL_RED);
    end else if (cut) begin
      // Independent of en and of the prescaler; a coincident tick still pulses.
      count_n = 4'(T_PED_CUT);
    end else if (fire) begin
      if (count != 4'd1) begin
        count_n = count - 4'd1;
      end else begin
        if (phase == PH_CAR_GREEN && !ped_any) phase_n = PH_CAR_GREEN;
        else                                   phase_n = next_phase(phase);
        count_n = phase_dur(phase_n);
      end
    end
    // Entering WALK serves the request; requests during WALK itself are dropped.
    if (phase_n == PH_WALK && phase != PH_WALK)  pend_n = 1'b0;
    else if (ped_req && phase != PH_WALK)        pend_n = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase       <= PH_CAR_GREEN;
      count       <= 4'(T_CAR_GREEN);
      tick        <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      phase       <= phase_n;
      count       <= count_n;
      tick        <= fire;
      ped_pending <= pend_n;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboarded bench for phase_sequencer: a per-second timing model predicts each
// cycle's outputs; a monitor pops and compares them after every clock edge.
module tb_phase_sequencer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] phase;
  logic [3:0] count;
  logic       tick;
  logic       ped_pending;

  always #5 clk = ~clk;

  phase_sequencer #(.TICK_DIV(DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .ped_req     (ped_req),
    .phase       (phase),
    .count       (count),
    .tick        (tick),
    .ped_pending (ped_pending)
  );

  typedef struct packed {
    logic [2:0] ph;
    logic [3:0] cnt;
    logic       tk;
    logic       pend;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: phase number, seconds left, clocks into the current second, latch.
  int   m_ph, m_cnt, m_pre;
  bit   m_pend;
  int   dur[6] = '{9, 3, 2, 9, 5, 2};

  task automatic model_reset();
    m_ph = 0; m_cnt = 9; m_pre = 0; m_pend = 0;
  endtask

  task automatic model_step(input bit e, input bit r, output bit t);
    int  nph, ncnt;
    bit  sec;
    sec  = e && (m_pre == DIV - 1);
    nph  = m_ph;
    ncnt = m_cnt;
    if (m_ph > 5) begin
      nph = 2; ncnt = dur[2];
    end else if (m_ph == 0 && (r || m_pend) && m_cnt > 3) begin
      ncnt = 3;
    end else if (sec) begin
      if (m_cnt > 1) ncnt = m_cnt - 1;
      else begin
        if (m_ph == 0) nph = (r || m_pend) ? 1 : 0;
        else           nph = (m_ph + 1) % 6;
        ncnt = dur[nph];
      end
    end
    if (nph == 3 && m_ph != 3) m_pend = 0;
    else if (r && m_ph != 3)   m_pend = 1;
    if (e) m_pre = sec ? 0 : m_pre + 1;
    m_ph = nph; m_cnt = ncnt; t = sec;
  endtask

  // Called at a falling edge: drive inputs for the next rising edge and queue the prediction.
  task automatic step(input bit e, input bit r);
    bit   t;
    exp_t x;
    en = e; ped_req = r;
    model_step(e, r, t);
    x.ph = 3'(m_ph); x.cnt = 4'(m_cnt); x.tk = t; x.pend = m_pend;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic check_reset(input string name);
    checks++;
    if ({phase, count, tick, ped_pending} !== {3'd0, 4'd9, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s: got ph=%0d cnt=%0d tick=%0b pend=%0b, want ph=0 cnt=9 tick=0 pend=0",
               name, phase, count, tick, ped_pending);
    end
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1 check_reset("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic force_illegal();
    force dut.phase = 3'd6;
    #1 release dut.phase;
    m_ph = 6;
    step(0, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({phase, count, tick, ped_pending} !== e) begin
        errors++;
        $display("FAIL cycle@%0t: got ph=%0d cnt=%0d tick=%0b pend=%0b, want ph=%0d cnt=%0d tick=%0b pend=%0b",
                 $time, phase, count, tick, ped_pending, e.ph, e.cnt, e.tk, e.pend);
      end
    end
  end

  initial begin
    model_reset();
    #3 rst = 1'b1;
    #1 check_reset("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // free-running car green
    repeat (40) step(1, 0);

    // request at count 7 cuts green, then through to WALK
    for (int i = 0; i < 100 && !(m_ph == 0 && m_cnt == 7); i++) step(1, 0);
    step(1, 1);
    for (int i = 0; i < 200 && m_ph != 3; i++) step(1, 0);

    // request ignored in WALK, latched in WALK_FLASH, cut on return to green
    repeat (5) step(1, 0);
    step(1, 1);
    for (int i = 0; i < 200 && m_ph != 4; i++) step(1, 0);
    repeat (3) step(1, 0);
    step(1, 1);
    for (int i = 0; i < 200 && m_ph != 0; i++) step(1, 0);
    repeat (6) step(1, 0);

    // pause mid-yellow
    for (int i = 0; i < 400 && !(m_ph == 1 && m_cnt == 2); i++) step(1, 0);
    step(1, 0);
    repeat (20) step(0, 0);
    repeat (20) step(1, 0);

    // cut while paused
    for (int i = 0; i < 400 && !(m_ph == 0 && m_cnt > 5 && !m_pend); i++) step(1, 0);
    repeat (2) step(0, 0);
    step(0, 1);
    repeat (6) step(0, 0);
    repeat (8) step(1, 0);

    // request coincident with the last green second
    for (int i = 0; i < 800 && !(m_ph == 0 && m_cnt == 1 && m_pre == DIV - 1 && !m_pend); i++)
      step(1, 0);
    step(1, 1);
    repeat (10) step(1, 0);

    // async reset mid-WALK, then illegal phase recovery
    for (int i = 0; i < 400 && m_ph != 3; i++) step(1, 0);
    repeat (3) step(1, 0);
    mid_reset();
    repeat (6) step(1, 0);
    force_illegal();
    repeat (10) step(1, 0);

    // random traffic
    repeat (3000) step($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
